// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage that sits after the PC register. It issues one
//                req/gnt read per instruction to instruction memory, waits for
//                the rvalid response and presents the instruction and its PC
//                to decode over a valid/ready handshake. The unit also drives
//                pc_stall, handles flush on redirect and runs a sticky
//                response-timeout watchdog.
//  Option      : IFU_ALIGN_CHECK_EN - when defined, a misaligned fetch address
//                is not requested. A NOP is presented instead, together with
//                the misalign_err output.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
   parameter logic [31:0] RESET_ADDR  = 32'h0000_0000,
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_out,
   output logic [31:0] instr_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
`ifdef IFU_ALIGN_CHECK_EN
   output logic        misalign_err,
`endif
   output logic        pc_stall,
   output logic        timeout_err
);

   localparam logic [2:0]  c_st_idle  = 3'd0;
   localparam logic [2:0]  c_st_req   = 3'd1;
   localparam logic [2:0]  c_st_wait  = 3'd2;
   localparam logic [2:0]  c_st_drain = 3'd3;
   localparam logic [2:0]  c_st_hold  = 3'd4;

   localparam logic [31:0] c_nop      = 32'h0000_0013;
   localparam logic [7:0]  c_timeout  = 8'(TIMEOUT_CYC);

   logic [2:0]  state_q, state_d;
   logic [31:0] fa_q, fa_d;
   logic [31:0] instr_out_q, instr_out_d;
   logic [31:0] instr_pc_q, instr_pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic        timeout_err_q, timeout_err_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        misalign_q, misalign_d;
   logic        w_misaligned;

`ifdef IFU_ALIGN_CHECK_EN
   assign w_misaligned = (fa_q[1:0] != 2'b00);
`else
   assign w_misaligned = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= c_st_idle;
      else       state_q <= state_d;
   end

   // Next-state logic; flush in REQ with a grant still owes one stale response
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_st_idle:  state_d = c_st_req;
         c_st_req: begin
            if (w_misaligned) begin
               if (!flush) state_d = c_st_hold;
            end else if (imem_gnt) begin
               state_d = flush ? c_st_drain : c_st_wait;
            end
         end
         c_st_wait: begin
            if (flush)            state_d = imem_rvalid ? c_st_req : c_st_drain;
            else if (imem_rvalid) state_d = c_st_hold;
         end
         c_st_drain: if (imem_rvalid)          state_d = c_st_req;
         c_st_hold:  if (flush || instr_ready) state_d = c_st_req;
         default:    state_d = c_st_idle;
      endcase
   end

   // FSM outputs; the PC may only advance on a decode handshake or on a redirect
   always_comb begin
      imem_req = (state_q == c_st_req) && !w_misaligned;
      pc_stall = !(((state_q == c_st_hold) && (instr_ready || flush)) ||
                   ((state_q == c_st_req) && flush));
   end

   // Datapath registers: fetch address, held instruction, watchdog
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fa_q          <= RESET_ADDR;
         instr_out_q   <= c_nop;
         instr_pc_q    <= 32'h0000_0000;
         instr_valid_q <= 1'b0;
         timeout_err_q <= 1'b0;
         cnt_q         <= 8'd0;
         misalign_q    <= 1'b0;
      end else begin
         fa_q          <= fa_d;
         instr_out_q   <= instr_out_d;
         instr_pc_q    <= instr_pc_d;
         instr_valid_q <= instr_valid_d;
         timeout_err_q <= timeout_err_d;
         cnt_q         <= cnt_d;
         misalign_q    <= misalign_d;
      end
   end

   // Datapath next values; pc_in is the only source of fetch addresses
   always_comb begin
      fa_d          = fa_q;
      instr_out_d   = instr_out_q;
      instr_pc_d    = instr_pc_q;
      instr_valid_d = instr_valid_q;
      timeout_err_d = timeout_err_q;
      cnt_d         = cnt_q;
      misalign_d    = misalign_q;
      case (state_q)
         c_st_idle: fa_d = pc_in;
         c_st_req: begin
            if (flush) begin
               fa_d = pc_in;
            end else if (w_misaligned) begin
               instr_out_d   = c_nop;
               instr_pc_d    = fa_q;
               instr_valid_d = 1'b1;
               misalign_d    = 1'b1;
            end
            if (imem_gnt && !w_misaligned) cnt_d = 8'd0;
         end
         c_st_wait: begin
            // counter saturates at the limit so the flag cannot re-trigger
            if (cnt_q != c_timeout) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == c_timeout) timeout_err_d = 1'b1;
            end
            if (flush) begin
               fa_d = pc_in;
            end else if (imem_rvalid) begin
               instr_out_d   = imem_rdata;
               instr_pc_d    = fa_q;
               instr_valid_d = 1'b1;
            end
         end
         c_st_drain: if (flush) fa_d = pc_in;
         c_st_hold: begin
            if (flush || instr_ready) begin
               instr_valid_d = 1'b0;
               misalign_d    = 1'b0;
               fa_d          = pc_in;
            end
         end
         default: ;
      endcase
   end

   assign imem_addr   = {fa_q[31:2], 2'b00};
   assign instr_out   = instr_out_q;
   assign instr_pc    = instr_pc_q;
   assign instr_valid = instr_valid_q;
   assign timeout_err = timeout_err_q;

`ifdef IFU_ALIGN_CHECK_EN
   assign misalign_err = misalign_q;
`else
   logic w_unused;
   assign w_unused = misalign_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed scoreboard bench for instr_fetch_unit. Expected
//                {instr, pc} pairs are queued by the stimulus and popped by a
//                monitor on every decode handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc_in;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        pc_stall;
   logic        timeout_err;
`ifdef IFU_ALIGN_CHECK_EN
   logic        misalign_err;
`endif

   int errors = 0;
   int checks = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   instr_fetch_unit #(
      .RESET_ADDR  (32'h0000_0000),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .pc_in       (pc_in),
      .flush       (flush),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
`ifdef IFU_ALIGN_CHECK_EN
      .misalign_err(misalign_err),
`endif
      .pc_stall    (pc_stall),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_req"},    {31'd0, imem_req},    32'd0);
      chk({tag, "_instr"},  instr_out,            32'h0000_0013);
      chk({tag, "_pc"},     instr_pc,             32'd0);
      chk({tag, "_valid"},  {31'd0, instr_valid}, 32'd0);
      chk({tag, "_tmo"},    {31'd0, timeout_err}, 32'd0);
      chk({tag, "_stall"},  {31'd0, pc_stall},    32'd1);
   endtask

   // Monitor: every accepted instruction must match the head of the queue
   always @(negedge clk) begin
      if (!reset && instr_valid && instr_ready && !flush) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got instr %h pc %h expected nothing", instr_out, instr_pc);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if ({instr_out, instr_pc} !== e) begin
               errors++;
               $display("FAIL sb_data: got instr %h pc %h expected instr %h pc %h",
                        instr_out, instr_pc, e[63:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; pc_in = 32'd0; flush = 1'b0; imem_gnt = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
      step(); step();
      chk_reset_vals("rst");
      reset = 1'b0;

      // Basic fetch: immediate grant, rvalid next cycle, decode ready
      imem_gnt = 1'b1; instr_ready = 1'b1;
      step();                                            // REQ
      chk("t1_req",   {31'd0, imem_req}, 32'd1);
      chk("t1_addr",  imem_addr, 32'd0);
      chk("t1_stall_req", {31'd0, pc_stall}, 32'd1);
      exp_q.push_back({32'h0050_0093, 32'h0});
      step();                                            // WAIT
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
      chk("t1_stall_wait", {31'd0, pc_stall}, 32'd1);
      step();                                            // HOLD, handshake
      imem_rvalid = 1'b0; pc_in = 32'h4;
      chk("t1_valid", {31'd0, instr_valid}, 32'd1);
      chk("t1_stall_hold", {31'd0, pc_stall}, 32'd0);
      step();                                            // REQ fa=4
      chk("t1_stall_after", {31'd0, pc_stall}, 32'd1);
      instr_ready = 1'b0;

      // Grant withheld for 3 cycles: request stable, no output
      for (int i = 0; i < 3; i++) begin
         chk("t2_req",   {31'd0, imem_req}, 32'd1);
         chk("t2_addr",  imem_addr, 32'h4);
         chk("t2_stall", {31'd0, pc_stall}, 32'd1);
         chk("t2_valid", {31'd0, instr_valid}, 32'd0);
         step();
      end
      imem_gnt = 1'b1;
      step();                                            // WAIT
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
      exp_q.push_back({32'h00A0_0113, 32'h4});
      step();                                            // HOLD, ready low
      imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF; pc_in = 32'h8;
      for (int i = 0; i < 4; i++) begin
         chk("t3_instr", instr_out, 32'h00A0_0113);
         chk("t3_pc",    instr_pc,  32'h4);
         chk("t3_valid", {31'd0, instr_valid}, 32'd1);
         chk("t3_stall", {31'd0, pc_stall}, 32'd1);
         step();
      end
      instr_ready = 1'b1;
      step();                                            // REQ fa=8

      // Flush in WAIT, stale response two cycles later
      imem_gnt = 1'b1;
      step();                                            // WAIT
      imem_gnt = 1'b0; flush = 1'b1; pc_in = 32'h100;
      step();                                            // DRAIN
      flush = 1'b0;
      chk("t4_stall", {31'd0, pc_stall}, 32'd1);
      chk("t4_req",   {31'd0, imem_req}, 32'd0);
      step();
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();                                            // REQ
      imem_rvalid = 1'b0;
      chk("t4_req2",  {31'd0, imem_req}, 32'd1);
      chk("t4_addr",  imem_addr, 32'h100);
      chk("t4_valid", {31'd0, instr_valid}, 32'd0);
      imem_gnt = 1'b1;
      step();                                            // WAIT
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
      exp_q.push_back({32'h1234_5678, 32'h100});
      step();                                            // HOLD
      imem_rvalid = 1'b0; pc_in = 32'h104;
      step();                                            // REQ fa=0x104

      // Timeout watchdog
      imem_gnt = 1'b1;
      step();                                            // WAIT, counter 0
      imem_gnt = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("t5_tmo_pre", {31'd0, timeout_err}, 32'd0);
      step();
      chk("t5_tmo_set", {31'd0, timeout_err}, 32'd1);
      imem_rvalid = 1'b1; imem_rdata = 32'h0000_A023;
      exp_q.push_back({32'h0000_A023, 32'h104});
      step();                                            // HOLD
      imem_rvalid = 1'b0; pc_in = 32'h108;
      chk("t5_tmo_hold", {31'd0, timeout_err}, 32'd1);
      step();                                            // REQ fa=0x108
      chk("t5_tmo_sticky", {31'd0, timeout_err}, 32'd1);

      // Asynchronous reset in the middle of WAIT
      imem_gnt = 1'b1;
      step();                                            // WAIT
      imem_gnt = 1'b0;
      step();
      #2 reset = 1'b1;
      #1 chk_reset_vals("arst");
      pc_in = 32'h200;
      #1 reset = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
      step();                                            // REQ, late rvalid
      step();
      imem_rvalid = 1'b0;
      chk("t6_valid", {31'd0, instr_valid}, 32'd0);
      chk("t6_req",   {31'd0, imem_req}, 32'd1);
      chk("t6_addr",  imem_addr, 32'h200);
      imem_gnt = 1'b1;
      step();                                            // WAIT
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
      exp_q.push_back({32'h0010_0073, 32'h200});
      step();                                            // HOLD
      imem_rvalid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
      pc_in = 32'h102;
      step();                                            // REQ fa=0x102
      instr_ready = 1'b0;
      chk("t7_req", {31'd0, imem_req}, 32'd0);
      exp_q.push_back({32'h0000_0013, 32'h102});
      step();                                            // HOLD
      chk("t7_mis",   {31'd0, misalign_err}, 32'd1);
      chk("t7_instr", instr_out, 32'h0000_0013);
      chk("t7_pc",    instr_pc, 32'h102);
      chk("t7_valid", {31'd0, instr_valid}, 32'd1);
      instr_ready = 1'b1;
`endif
      step();
      instr_ready = 1'b0;
      step(); step();
      chk("sb_empty", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
